// File: rtl/if_fetch.sv
// Instruction-fetch stage: drives the PC register and instruction memory, and
// fills the IF/ID pipeline register with one instruction per accepted fetch.
module if_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_ld,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [1:0]  o_dbg_state
);

  // Memory handshake: imem_req is held with imem_addr stable (pc only moves on
  // pc_ld) until the cycle imem_ack=1; that cycle transfers imem_rdata and
  // completes the request. There is no outstanding request after that edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    IFID_KEEP  = 2'd0,
    IFID_MEM   = 2'd1,
    IFID_BUF   = 2'd2,
    IFID_CLEAR = 2'd3
  } ifid_op_t;

  state_t      r_state;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_pend_target;

  state_t      w_next_state;
  ifid_op_t    w_ifid_op;
  logic        w_pc_ld;
  logic [31:0] w_pc_next;
  logic        w_imem_req;
  logic        w_buf_ld;
  logic        w_buf_clr;
  logic        w_pend_ld;
  logic [31:0] w_pc4;

  // Wraps naturally at 2^32.
  assign w_pc4 = pc + 32'd4;

  always_comb begin
    w_next_state = r_state;
    w_pc_ld      = 1'b0;
    w_pc_next    = w_pc4;
    w_imem_req   = 1'b0;
    w_buf_ld     = 1'b0;
    w_buf_clr    = 1'b0;
    w_pend_ld    = 1'b0;
    w_ifid_op    = id_stall ? IFID_KEEP : IFID_CLEAR;
    if (redirect) begin
      w_ifid_op = IFID_CLEAR;
    end

    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            w_pc_ld   = 1'b1;
            w_pc_next = redirect_target;
          end else begin
            w_pend_ld    = 1'b1;
            w_next_state = S_KILL;
          end
        end else if (imem_ack) begin
          if (id_stall) begin
            w_buf_ld     = 1'b1;
            w_next_state = S_HOLD;
          end else begin
            w_pc_ld   = 1'b1;
            w_ifid_op = IFID_MEM;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_ld      = 1'b1;
          w_pc_next    = redirect_target;
          w_buf_clr    = 1'b1;
          w_next_state = S_FETCH;
        end else if (!id_stall) begin
          w_pc_ld      = 1'b1;
          w_pc_next    = r_buf_pc4;
          w_ifid_op    = IFID_BUF;
          w_buf_clr    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_KILL: begin
        // The old request must still complete; its data is thrown away.
        w_imem_req = 1'b1;
        if (redirect) begin
          w_pend_ld = 1'b1;
          if (imem_ack) begin
            w_pc_ld      = 1'b1;
            w_pc_next    = redirect_target;
            w_next_state = S_FETCH;
          end
        end else if (imem_ack) begin
          w_pc_ld      = 1'b1;
          w_pc_next    = r_pend_target;
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (!reset) begin
      w_imem_req = 1'b0;
      w_pc_ld    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ifid_valid  <= 1'b0;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_pc4    <= 32'd0;
      r_buf_instr   <= NOP_INSTR;
      r_buf_pc4     <= 32'd0;
      r_pend_target <= 32'd0;
    end else begin
      r_state <= w_next_state;

      case (w_ifid_op)
        IFID_MEM: begin
          r_ifid_valid <= 1'b1;
          r_ifid_instr <= imem_rdata;
          r_ifid_pc4   <= w_pc4;
        end
        IFID_BUF: begin
          r_ifid_valid <= 1'b1;
          r_ifid_instr <= r_buf_instr;
          r_ifid_pc4   <= r_buf_pc4;
        end
        IFID_CLEAR: begin
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= NOP_INSTR;
          r_ifid_pc4   <= 32'd0;
        end
        default: begin
        end
      endcase

      if (w_buf_ld) begin
        r_buf_instr <= imem_rdata;
        r_buf_pc4   <= w_pc4;
      end else if (w_buf_clr) begin
        r_buf_instr <= NOP_INSTR;
        r_buf_pc4   <= 32'd0;
      end

      if (w_pend_ld) begin
        r_pend_target <= redirect_target;
      end
    end
  end

  assign pc_ld       = w_pc_ld;
  assign pc_next     = w_pc_next;
  assign imem_req    = w_imem_req;
  assign imem_addr   = pc;
  assign ifid_valid  = r_ifid_valid;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_pc4    = r_ifid_pc4;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: models the PC register and a memory whose data
// is a function of address; delivered IF/ID words are scored against a queue.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_KILL  = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_ld;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [1:0]  o_dbg_state;

  logic        pc_set;
  logic [31:0] pc_set_val;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  if_fetch #(.NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_ld           (pc_ld),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .id_stall        (id_stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .o_dbg_state     (o_dbg_state)
  );

  // Clock / reset-value block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_ld) pc <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0040_0020) return 32'h2402_0005;
    return addr ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    chk32(tag, {30'd0, o_dbg_state}, {30'd0, exp});
  endtask

  // Advance one clock; when IF/ID was free to change and no redirect was
  // active, it must carry exactly the next expected word (or a bubble).
  task automatic cycle();
    logic        s_stall;
    logic        s_redir;
    logic        s_rst_n;
    logic        exp_v;
    logic [63:0] e;
    s_stall = id_stall;
    s_redir = redirect;
    s_rst_n = reset;
    @(posedge clk);
    #1;
    if (!s_stall && !s_redir) begin
      exp_v = s_rst_n && (exp_q.size() != 0);
      chk1("ifid_valid", ifid_valid, exp_v);
      if (ifid_valid && exp_v) begin
        e = exp_q.pop_front();
        chk32("ifid_instr", ifid_instr, e[63:32]);
        chk32("ifid_pc4", ifid_pc4, e[31:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] addr);
    exp_q.push_back({mem_word(addr), addr + 32'd4});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    id_stall        = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    imem_ack        = 1'b1;
    pc_set          = 1'b1;
    pc_set_val      = 32'h0040_0000;

    // Reset state.
    @(negedge clk);
    cycle();
    chk_state("rst_state", ST_IDLE);
    chk32("rst_instr", ifid_instr, NOP);
    chk32("rst_pc4", ifid_pc4, 32'd0);

    // One IDLE cycle, then zero-wait streaming from 0x0040_0000.
    reset  = 1'b1;
    pc_set = 1'b0;
    #1;
    chk1("idle_req", imem_req, 1'b0);
    chk1("idle_pc_ld", pc_ld, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h0040_0000 + 32'(4 * i));
      #1;
      chk1("stream_pc_ld", pc_ld, 1'b1);
      chk32("stream_pc_next", pc_next, 32'h0040_0004 + 32'(4 * i));
      cycle();
    end

    // Ack delayed three cycles at 0x0040_0010.
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk32("wait_addr", imem_addr, 32'h0040_0010);
      chk1("wait_req", imem_req, 1'b1);
      chk1("wait_pc_ld", pc_ld, 1'b0);
      cycle();
    end
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h0040_0010 + 32'(4 * i));
      cycle();
    end

    // Decode stall while 0x2402_0005 is returned from 0x0040_0020.
    id_stall = 1'b1;
    exp_q.push_back({32'h2402_0005, 32'h0040_0024});
    #1;
    chk1("stall_pc_ld", pc_ld, 1'b0);
    cycle();
    chk_state("hold_state", ST_HOLD);
    chk1("hold_valid", ifid_valid, 1'b1);
    chk32("hold_instr", ifid_instr, mem_word(32'h0040_001C));
    chk32("hold_pc4", ifid_pc4, 32'h0040_0020);
    #1;
    chk1("hold_req", imem_req, 1'b0);
    chk1("hold_pc_ld", pc_ld, 1'b0);
    cycle();
    chk32("hold_instr2", ifid_instr, mem_word(32'h0040_001C));
    id_stall = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk1("release_pc_ld", pc_ld, 1'b1);
    chk32("release_pc_next", pc_next, 32'h0040_0024);
    cycle();
    chk1("release_pulse_once", pc_ld, 1'b0);
    chk_state("release_state", ST_FETCH);

    // Redirect with no ack: KILL until the stale word returns.
    redirect        = 1'b1;
    redirect_target = 32'h0040_0100;
    #1;
    chk1("kill_entry_pc_ld", pc_ld, 1'b0);
    cycle();
    chk_state("kill_state", ST_KILL);
    chk1("kill_valid", ifid_valid, 1'b0);
    redirect = 1'b0;
    #1;
    chk1("kill_req", imem_req, 1'b1);
    chk32("kill_addr", imem_addr, 32'h0040_0024);
    chk1("kill_pc_ld", pc_ld, 1'b0);
    cycle();
    cycle();
    imem_ack = 1'b1;
    #1;
    chk1("kill_ack_pc_ld", pc_ld, 1'b1);
    chk32("kill_ack_pc_next", pc_next, 32'h0040_0100);
    cycle();
    chk32("kill_resume_addr", imem_addr, 32'h0040_0100);
    push_exp(32'h0040_0100);
    cycle();

    // Two redirects while in KILL: the latest one wins.
    imem_ack        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0100;
    cycle();
    redirect_target = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk32("latest_pc_next", pc_next, 32'h0000_0200);
    cycle();
    chk32("latest_addr", imem_addr, 32'h0000_0200);
    push_exp(32'h0000_0200);
    cycle();

    // Redirect coinciding with the ack while in KILL.
    imem_ack        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0300;
    cycle();
    imem_ack        = 1'b1;
    redirect_target = 32'h0000_0400;
    #1;
    chk1("kill_same_pc_ld", pc_ld, 1'b1);
    chk32("kill_same_pc_next", pc_next, 32'h0000_0400);
    cycle();
    redirect = 1'b0;
    chk_state("kill_same_state", ST_FETCH);
    push_exp(32'h0000_0400);
    cycle();

    // Redirect with ack in FETCH: returned word dropped.
    redirect        = 1'b1;
    redirect_target = 32'h0000_0500;
    #1;
    chk32("fetch_redir_pc_next", pc_next, 32'h0000_0500);
    cycle();
    chk1("fetch_redir_valid", ifid_valid, 1'b0);
    redirect = 1'b0;

    // PC wrap at the top of the address space.
    imem_ack   = 1'b0;
    pc_set     = 1'b1;
    pc_set_val = 32'hFFFF_FFFC;
    cycle();
    pc_set   = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk32("wrap_pc_next", pc_next, 32'h0000_0000);
    push_exp(32'hFFFF_FFFC);
    cycle();

    // Redirect while HOLD (stall still high) drops the buffered word.
    id_stall = 1'b1;
    cycle();
    chk_state("hold2_state", ST_HOLD);
    redirect        = 1'b1;
    redirect_target = 32'h0000_0600;
    #1;
    chk1("hold_redir_pc_ld", pc_ld, 1'b1);
    chk32("hold_redir_pc_next", pc_next, 32'h0000_0600);
    cycle();
    chk1("hold_redir_valid", ifid_valid, 1'b0);
    chk_state("hold_redir_state", ST_FETCH);
    redirect = 1'b0;
    id_stall = 1'b0;

    // Reset in the middle of an outstanding request.
    imem_ack = 1'b0;
    cycle();
    reset    = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_pc_ld", pc_ld, 1'b0);
    cycle();
    chk_state("mid_rst_state", ST_IDLE);
    reset    = 1'b1;
    imem_ack = 1'b0;
    cycle();
    imem_ack = 1'b1;
    chk32("post_rst_addr", imem_addr, 32'h0000_0600);
    push_exp(32'h0000_0600);
    cycle();

    chk32("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
